// File: rtl/dmem_lsu.sv
// dmem_lsu: word-organised data memory with a byte-addressed load/store port.
// The memory is cleared after reset, accepts one request per cycle, and returns
// exactly one response per request after a fixed READ_LAT-cycle pipeline.
module dmem_lsu #(
  parameter int DEPTH    = 256,
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_err_code,
  output logic [31:0] mem_word0
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] init_cnt_reg, init_cnt_next;
  logic          clear_en;

  // Request decode
  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          out_of_range;
  logic          misaligned;
  logic [1:0]    err_code_c;
  logic          req_err;
  logic [3:0]    store_be;
  logic [31:0]   store_data;
  logic          store_en;
  logic          rd_en;

  // Memory write port
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic [31:0]   rd_word;

  // First response stage (aligned with the registered memory read)
  logic          s0_valid_reg;
  logic          s0_load_reg;
  logic [1:0]    s0_code_reg;
  logic [1:0]    s0_size_reg;
  logic          s0_uns_reg;
  logic [1:0]    s0_lane_reg;
  logic [31:0]   ext_data;
  logic [7:0]    ext_byte;
  logic [15:0]   ext_half;

  // State register for the clear/run sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  // Next state: walk the clear counter through every word, then serve requests
  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    clear_en      = 1'b0;
    req_ready     = 1'b0;
    case (state_reg)
      ST_INIT: begin
        clear_en      = 1'b1;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == AW'(DEPTH - 1)) state_next = ST_RUN;
      end
      ST_RUN: req_ready = 1'b1;
      default: state_next = ST_INIT;
    endcase
  end

  assign accept       = req_valid & req_ready;
  assign word_idx     = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign out_of_range = |req_addr[31:AW+2];
  assign misaligned   = ((req_size == 2'b01) & req_addr[0]) |
                        ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));

  // Fault classification; illegal size outranks range, range outranks alignment
  always_comb begin
    err_code_c = 2'b00;
    if (req_size == 2'b11)  err_code_c = 2'b11;
    else if (out_of_range)  err_code_c = 2'b10;
    else if (misaligned)    err_code_c = 2'b01;
  end

  assign req_err = (err_code_c != 2'b00);

  // Replicate store data across lanes and pick the lanes it may touch
  always_comb begin
    store_be   = 4'b0000;
    store_data = req_wdata;
    case (req_size)
      2'b00: begin
        store_be   = 4'b0001 << lane;
        store_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        store_be   = lane[1] ? 4'b1100 : 4'b0011;
        store_data = {2{req_wdata[15:0]}};
      end
      2'b10: store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  end

  assign store_en = accept & req_write & ~req_err;
  assign rd_en    = accept & ~req_write & ~req_err;

  // Write port arbitration: clearing owns the port in INIT, nothing writes in reset
  always_comb begin
    wr_idx  = word_idx;
    wr_data = store_data;
    wr_be   = 4'b0000;
    if (!rst_n) begin
      wr_be = 4'b0000;
    end else if (clear_en) begin
      wr_idx  = init_cnt_reg;
      wr_data = '0;
      wr_be   = 4'b1111;
    end else if (store_en) begin
      wr_be = store_be;
    end
  end

  // One byte-wide RAM per lane so byte enables map onto plain write enables
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH];
    logic [7:0] rd_lane_reg;

    // Lane write and registered read; a load sees memory as it was before this edge
    always_ff @(posedge clk) begin
      if (wr_be[gi]) lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
      if (rd_en)     rd_lane_reg      <= lane_mem[word_idx];
    end

    assign rd_word[gi*8 +: 8]   = rd_lane_reg;
    assign mem_word0[gi*8 +: 8] = lane_mem[0];
  end

  // Capture request attributes alongside the memory read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid_reg <= 1'b0;
      s0_load_reg  <= 1'b0;
      s0_code_reg  <= 2'b00;
      s0_size_reg  <= 2'b00;
      s0_uns_reg   <= 1'b0;
      s0_lane_reg  <= 2'b00;
    end else begin
      s0_valid_reg <= accept;
      s0_load_reg  <= rd_en;
      s0_code_reg  <= accept ? err_code_c : 2'b00;
      s0_size_reg  <= req_size;
      s0_uns_reg   <= req_unsigned;
      s0_lane_reg  <= lane;
    end
  end

  assign ext_byte = rd_word[{s0_lane_reg, 3'b000} +: 8];
  assign ext_half = s0_lane_reg[1] ? rd_word[31:16] : rd_word[15:0];

  // Load alignment and extension; stores and faults return zero
  always_comb begin
    ext_data = '0;
    if (s0_valid_reg && s0_load_reg) begin
      case (s0_size_reg)
        2'b00:   ext_data = s0_uns_reg ? {24'h0, ext_byte} : {{24{ext_byte[7]}}, ext_byte};
        2'b01:   ext_data = s0_uns_reg ? {16'h0, ext_half} : {{16{ext_half[15]}}, ext_half};
        2'b10:   ext_data = rd_word;
        default: ext_data = '0;
      endcase
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign rsp_valid    = s0_valid_reg;
    assign rsp_rdata    = ext_data;
    assign rsp_err_code = s0_code_reg;
  end else begin : g_latn
    logic [READ_LAT-2:0] dly_valid_reg;
    logic [31:0]         dly_data_reg [READ_LAT-1];
    logic [1:0]          dly_code_reg [READ_LAT-1];

    // Delay line padding the response out to the configured latency
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dly_valid_reg <= '0;
        for (int i = 0; i < READ_LAT - 1; i++) begin
          dly_data_reg[i] <= '0;
          dly_code_reg[i] <= 2'b00;
        end
      end else begin
        dly_valid_reg[0] <= s0_valid_reg;
        dly_data_reg[0]  <= ext_data;
        dly_code_reg[0]  <= s0_code_reg;
        for (int i = 1; i < READ_LAT - 1; i++) begin
          dly_valid_reg[i] <= dly_valid_reg[i-1];
          dly_data_reg[i]  <= dly_data_reg[i-1];
          dly_code_reg[i]  <= dly_code_reg[i-1];
        end
      end
    end

    assign rsp_valid    = dly_valid_reg[READ_LAT-2];
    assign rsp_rdata    = dly_data_reg[READ_LAT-2];
    assign rsp_err_code = dly_code_reg[READ_LAT-2];
  end

  assign rsp_err = (rsp_err_code != 2'b00);

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: drives two dmem_lsu instances (READ_LAT 2 and 4) with the same
// directed requests and checks every response against hand-computed values.
module tb_dmem_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rdy2, rv2, re2;
  logic [31:0] rd2, w02;
  logic [1:0]  rc2;
  logic        rdy4, rv4, re4;
  logic [31:0] rd4, w04;
  logic [1:0]  rc4;

  typedef struct packed {
    int          acc;
    logic [31:0] data;
    logic [1:0]  code;
  } rsp_t;

  rsp_t        q2[$];
  rsp_t        q4[$];
  int          cyc;
  int          total;
  int          bad;
  bit          mon_en;
  logic [31:0] exp_data;
  logic [1:0]  exp_code;

  dmem_lsu #(.DEPTH(256), .READ_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy2),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv2),
    .rsp_rdata(rd2), .rsp_err(re2), .rsp_err_code(rc2), .mem_word0(w02)
  );

  dmem_lsu #(.DEPTH(256), .READ_LAT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy4),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv4),
    .rsp_rdata(rd4), .rsp_err(re4), .rsp_err_code(rc4), .mem_word0(w04)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Record every accepted request with the response it must produce
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      q2.delete();
      q4.delete();
    end else begin
      if (req_valid && rdy2) q2.push_back('{cyc, exp_data, exp_code});
      if (req_valid && rdy4) q4.push_back('{cyc, exp_data, exp_code});
    end
  end

  task automatic mon_one(input string nm, input int lat, input bit have, input rsp_t f,
                         input logic v, input logic [31:0] d, input logic e,
                         input logic [1:0] c, output bit pop);
    pop = 1'b0;
    if (have && (f.acc + lat == cyc)) begin
      pop = 1'b1;
      chk({nm, " valid"}, v, 32'd1);
      chk({nm, " rdata"}, d, f.data);
      chk({nm, " err"}, e, (f.code != 2'b00) ? 32'd1 : 32'd0);
      chk({nm, " code"}, c, f.code);
      $display("%s rsp acc=%0d rdata=%08h err=%0b code=%0d", nm, f.acc, d, e, c);
    end else begin
      chk({nm, " idle"}, v, 32'd0);
    end
  endtask

  bit   p2, p4;
  rsp_t f2, f4;

  always @(negedge clk) begin
    if (mon_en) begin
      f2 = (q2.size() > 0) ? q2[0] : '0;
      f4 = (q4.size() > 0) ? q4[0] : '0;
      mon_one("lat2", 2, q2.size() > 0, f2, rv2, rd2, re2, rc2, p2);
      mon_one("lat4", 4, q4.size() > 0, f4, rv4, rd4, re4, rc4, p4);
      if (p2) void'(q2.pop_front());
      if (p4) void'(q4.pop_front());
    end
  end

  task automatic send(input bit w, input bit [1:0] sz, input bit u, input bit [31:0] a,
                      input bit [31:0] wd, input bit [31:0] ed, input bit [1:0] ec);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    exp_data     = ed;
    exp_code     = ec;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!rdy2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " cycles"}, n, 32'd256);
    chk({tag, " rdy4"}, rdy4, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by time limit, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    exp_data = '0; exp_code = 2'b00; mon_en = 1'b0;
    total = 0; bad = 0; cyc = 0;

    repeat (3) @(negedge clk);
    chk("rst rdy2", rdy2, 0);  chk("rst rdy4", rdy4, 0);
    chk("rst rv2", rv2, 0);    chk("rst rv4", rv4, 0);
    chk("rst rd2", rd2, 0);    chk("rst rd4", rd4, 0);
    chk("rst re2", re2, 0);    chk("rst re4", re4, 0);
    chk("rst rc2", rc2, 0);    chk("rst rc4", rc4, 0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    wait_ready("init");
    chk("init w0_2", w02, 32'h0);
    chk("init w0_4", w04, 32'h0);

    // Cleared memory, store then loads of every size and extension
    send(0, 2'b10, 0, 32'h3FC, 32'h0,        32'h00000000, 2'b00);
    send(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h00000000, 2'b00);
    send(0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 2'b00);
    send(0, 2'b00, 1, 32'h13,  32'h0,        32'h000000DE, 2'b00);
    send(0, 2'b00, 0, 32'h11,  32'h0,        32'hFFFFFFBE, 2'b00);
    send(0, 2'b01, 1, 32'h12,  32'h0,        32'h0000DEAD, 2'b00);
    send(0, 2'b01, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 2'b00);
    send(0, 2'b10, 1, 32'h10,  32'h0,        32'hDEADBEEF, 2'b00);

    // Partial stores into word 0
    send(1, 2'b10, 0, 32'h0, 32'h11223344, 32'h0, 2'b00);
    chk("w0 word 2", w02, 32'h11223344);
    chk("w0 word 4", w04, 32'h11223344);
    send(1, 2'b01, 0, 32'h2, 32'h5555AABB, 32'h0, 2'b00);
    chk("w0 half 2", w02, 32'hAABB3344);
    chk("w0 half 4", w04, 32'hAABB3344);
    send(0, 2'b01, 1, 32'h0, 32'h0, 32'h00003344, 2'b00);
    send(0, 2'b01, 0, 32'h2, 32'h0, 32'hFFFFAABB, 2'b00);
    send(0, 2'b00, 0, 32'h1, 32'h0, 32'h00000033, 2'b00);
    send(1, 2'b00, 0, 32'h21, 32'h1234565A, 32'h0, 2'b00);
    send(0, 2'b10, 0, 32'h20, 32'h0, 32'h00005A00, 2'b00);

    // Faults, including priority between codes; none may alter memory
    send(0, 2'b10, 0, 32'h6,   32'h0,        32'h0, 2'b01);
    send(1, 2'b00, 0, 32'h400, 32'h00000077, 32'h0, 2'b10);
    send(0, 2'b01, 0, 32'h1,   32'h0,        32'h0, 2'b01);
    send(1, 2'b10, 0, 32'h2,   32'hFFFFFFFF, 32'h0, 2'b01);
    send(1, 2'b11, 0, 32'h0,   32'hFFFFFFFF, 32'h0, 2'b11);
    send(0, 2'b11, 0, 32'h401, 32'h0,        32'h0, 2'b11);
    send(0, 2'b10, 0, 32'h402, 32'h0,        32'h0, 2'b10);
    chk("err w0 2", w02, 32'hAABB3344);
    chk("err w0 4", w04, 32'hAABB3344);
    send(0, 2'b10, 0, 32'h0, 32'h0, 32'hAABB3344, 2'b00);

    // Back-to-back alternating store/load
    for (int i = 0; i < 4; i++) begin
      send(1, 2'b10, 0, 32'h40 + 4 * i, 32'hC0DE0000 + 32'h1111 * i, 32'h0, 2'b00);
      send(0, 2'b10, 0, 32'h40 + 4 * i, 32'h0, 32'hC0DE0000 + 32'h1111 * i, 2'b00);
    end
    idle(6);

    // Reset with three loads in flight
    send(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
    send(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
    send(0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready("reinit");
    chk("reinit w0_2", w02, 32'h0);
    chk("reinit w0_4", w04, 32'h0);
    send(0, 2'b10, 0, 32'h10, 32'h0, 32'h0, 2'b00);
    send(0, 2'b10, 0, 32'h40, 32'h0, 32'h0, 2'b00);
    idle(6);

    chk("drain lat2", q2.size(), 32'd0);
    chk("drain lat4", q4.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
